// File: rtl/fg_node_seq.sv
// Operand/result sequencer for the polar-decoder f/g unit: loads one 16-LLR node,
// runs an f pass, waits for left-subtree partial sums, then runs a g pass.
module fg_node_seq #(
    parameter int unsigned LLR_W  = 8,
    parameter int unsigned PE_NUM = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*PE_NUM*LLR_W-1:0]     in_llr,
    input  logic                          ps_valid,
    output logic                          ps_ready,
    input  logic [PE_NUM-1:0]             ps_bits,
    output logic [2*PE_NUM*LLR_W-1:0]     pu_llr,
    output logic [PE_NUM-1:0]             pu_bit,
    output logic                          pu_flag,
    input  logic [PE_NUM*LLR_W-1:0]       pu_llr_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PE_NUM*LLR_W-1:0]       out_llr,
    output logic                          out_is_g,
    input  logic                          flush,
    output logic                          busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFCalc,
        StFOut,
        StWaitPs,
        StGCalc,
        StGOut
    } state_e;

    state_e                      state_q;
    logic [2*PE_NUM*LLR_W-1:0]   op_q;
    logic [PE_NUM-1:0]           bit_q;

    // Flush only redirects the state; operand, bit and result registers keep contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            bit_q    <= '0;
            out_llr  <= '0;
            out_is_g <= 1'b0;
            pu_flag  <= 1'b1;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q    <= in_llr;
                        pu_flag <= 1'b1;
                        state_q <= StFCalc;
                    end
                end
                StFCalc: begin
                    out_llr  <= pu_llr_out;
                    out_is_g <= 1'b0;
                    state_q  <= StFOut;
                end
                StFOut: begin
                    if (out_ready) begin
                        pu_flag <= 1'b0;
                        state_q <= StWaitPs;
                    end
                end
                StWaitPs: begin
                    if (ps_valid) begin
                        bit_q   <= ps_bits;
                        state_q <= StGCalc;
                    end
                end
                StGCalc: begin
                    out_llr  <= pu_llr_out;
                    out_is_g <= 1'b1;
                    state_q  <= StGOut;
                end
                StGOut: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign ps_ready  = (state_q == StWaitPs);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StFOut) || (state_q == StGOut);
    assign pu_llr    = op_q;
    // Partial sums only matter to the unit during the g pass.
    assign pu_bit    = (state_q == StGCalc) ? bit_q : '0;

endmodule

// File: doc/fg_node_seq.md
# fg_node_seq

Sequencer that sits directly upstream of the polar-decoder f/g processing unit and owns its operands. It accepts one 16-LLR node from the LLR memory, drives the unit through an f pass, returns the 8 f-LLRs downstream, waits for the 8 partial-sum bits of the left subtree, then drives a g pass and returns the 8 g-LLRs. All operands and results are registered, so the combinational f/g unit sees stable inputs for a full cycle.

## Interface
- LLR_W, 8, internal LLR width (two's complement), equal to the unit's internal LLR length
- PE_NUM, 8, number of PEs; node width is 2*PE_NUM LLRs

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  node operands valid
- in_ready  out  1  sequencer can accept a node; equals (state==IDLE)
- in_llr  in  2*PE_NUM*LLR_W  node LLRs; LLR k at [k*LLR_W +: LLR_W]
- ps_valid  in  1  partial sums valid
- ps_ready  out  1  equals (state==WAIT_PS)
- ps_bits  in  PE_NUM  partial sum for PE j at bit j
- pu_llr  out  2*PE_NUM*LLR_W  to unit LLR input; PE j gets LLR 2j (a) and 2j+1 (b)
- pu_bit  out  PE_NUM  to unit bit input
- pu_flag  out  1  to unit f/g select; 1 = f, 0 = g
- pu_llr_out  in  PE_NUM*LLR_W  unit result; PE j at [j*LLR_W +: LLR_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_llr  out  PE_NUM*LLR_W  registered result
- out_is_g  out  1  0 = f result, 1 = g result
- flush  in  1  synchronous abort to IDLE
- busy  out  1  state != IDLE

## Operation
- States: IDLE, F_CALC, F_OUT, WAIT_PS, G_CALC, G_OUT.
- IDLE: in_valid&in_ready → load in_llr into operand register, go F_CALC.
- F_CALC: pu_flag=1, pu_bit=0; capture pu_llr_out into out_llr, out_is_g←0; go F_OUT.
- F_OUT: out_valid=1; on out_ready go WAIT_PS.
- WAIT_PS: on ps_valid capture ps_bits into bit register, go G_CALC.
- G_CALC: pu_flag=0, pu_bit=bit register; capture pu_llr_out, out_is_g←1; go G_OUT.
- G_OUT: out_valid=1; on out_ready go IDLE.
- pu_llr always equals the operand register; operand register changes only on IDLE accept.
- pu_flag registered: 1 in F_CALC/F_OUT, 0 in WAIT_PS/G_CALC/G_OUT; holds last value in IDLE.
- Arithmetic is entirely in the unit; this block does no width change or saturation.
- ps_valid outside WAIT_PS is ignored (ps_ready=0); in_valid outside IDLE is ignored.
- flush: highest priority; any state → IDLE next cycle, out_valid deasserts next cycle, operand/bit/out_llr registers keep contents. flush coincident with in_valid in IDLE: node is not accepted.
- out_llr and out_is_g stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, async): state IDLE, in_ready=1, ps_ready=0, out_valid=0, busy=0, out_is_g=0, pu_flag=1, pu_bit=0, pu_llr=0, out_llr=0.
- Node accepted at edge T → F_CALC in cycle T+1 → out_valid=1 from T+2 (f latency 2).
- Partial sums accepted at edge M → out_valid=1 from M+2 (g latency 2).
- out_ready high in the first out_valid cycle: out_valid lasts exactly one cycle.
- Back-to-back: G_OUT handshake at edge E → in_ready=1 in cycle E+1; minimum node period 6 cycles with all handshakes immediate.
- Reset mid-operation: immediate return to reset values; no partial result emitted.

## Test plan
- Reset: assert rst_n=0 mid-G_CALC → same cycle out_valid=0, busy=0, in_ready=1; all outputs at reset values.
- f pass: PE0 pair (a=5, b=−3), PE1 (−4, −6), others (1,2), out_ready=1 → out_valid at T+2, out_is_g=0, PE0=−3, PE1=4, others 1.
- g pass: same node, ps_bits=8'b0000_0001 → PE0 = b−a = −8, PE1 = b+a = −10, others 3, out_is_g=1, latency 2 from ps accept.
- Backpressure: hold out_ready=0 for 5 cycles in F_OUT, toggle in_llr and ps_valid → out_llr stable, ps_bits not captured, in_ready=0.
- Flush: assert flush in WAIT_PS with ps_valid=1 → next cycle IDLE, no g result ever emitted; next node processes normally.
- Throughput: 4 random nodes with ready/valid always high, golden f/g model → outputs match, 6-cycle period, order f,g,f,g…
